// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - load-use stall, branch flush and memory freeze control for a 5-stage pipeline.
// Optional stall-cycle counter enabled by defining HAZARD_STALL_CNT_EN.
module hazard_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rt,
  input  logic [4:0]  ex_rd,
  input  logic        ex_load,
  input  logic        ex_rf_enable,
  input  logic        branch_taken,
  input  logic        mem_wait,
  output logic        pc_le,
  output logic        ifid_le,
  output logic        idex_nop,
  output logic        ifid_flush,
  output logic        pipe_freeze,
  output logic [1:0]  ctrl_state,
  output logic [15:0] stall_cnt
);

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    BUBBLE = 2'b01,
    FLUSH  = 2'b10,
    FREEZE = 2'b11
  } state_t;

  state_t state, state_next;
  logic   hazard;
  logic   stall;
  logic   advance;

  assign hazard = ex_load & ex_rf_enable & (ex_rd != 5'd0) &
                  ((ex_rd == id_rs) | (id_uses_rt & (ex_rd == id_rt)));

  // The bubble already inserted covers the load-use pair still visible in BUBBLE.
  assign stall   = hazard & (state != BUBBLE);
  assign advance = !mem_wait & !stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = RUN;
    pc_le       = advance;
    ifid_le     = advance;
    idex_nop    = !mem_wait & stall;
    ifid_flush  = (state == FLUSH) & !mem_wait;
    pipe_freeze = mem_wait;

    if (mem_wait) begin
      state_next = FREEZE;
    end else if (stall) begin
      state_next = BUBBLE;
    end else if (branch_taken) begin
      state_next = FLUSH;
    end

    // Reset drives a safe, all-NOP pipeline regardless of the clock.
    if (reset) begin
      pc_le       = 1'b0;
      ifid_le     = 1'b0;
      idex_nop    = 1'b1;
      ifid_flush  = 1'b1;
      pipe_freeze = 1'b0;
    end
  end

  assign ctrl_state = state;

`ifdef HAZARD_STALL_CNT_EN
  logic [15:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= 16'h0000;
    end else if (!advance && (cnt != 16'hFFFF)) begin
      cnt <= cnt + 16'h0001;
    end
  end

  assign stall_cnt = cnt;
`else
  assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard bench for hazard_ctrl against a pipeline-behaviour reference model.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  id_rs = '0;
  logic [4:0]  id_rt = '0;
  logic        id_uses_rt = 1'b0;
  logic [4:0]  ex_rd = '0;
  logic        ex_load = 1'b0;
  logic        ex_rf_enable = 1'b0;
  logic        branch_taken = 1'b0;
  logic        mem_wait = 1'b0;
  logic        pc_le, ifid_le, idex_nop, ifid_flush, pipe_freeze;
  logic [1:0]  ctrl_state;
  logic [15:0] stall_cnt;

  hazard_ctrl dut (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_rd(ex_rd), .ex_load(ex_load), .ex_rf_enable(ex_rf_enable),
    .branch_taken(branch_taken), .mem_wait(mem_wait),
    .pc_le(pc_le), .ifid_le(ifid_le), .idex_nop(idex_nop), .ifid_flush(ifid_flush),
    .pipe_freeze(pipe_freeze), .ctrl_state(ctrl_state), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        pc_le;
    logic        ifid_le;
    logic        idex_nop;
    logic        ifid_flush;
    logic        pipe_freeze;
    logic [1:0]  st;
    logic [15:0] cnt;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;

  // Reference model: what the pipeline did last cycle, not an FSM encoding.
  bit m_bubbled = 0;
  bit m_flush_due = 0;
  bit m_frozen = 0;
  int m_stalls = 0;

`ifdef HAZARD_STALL_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                      input logic [4:0] rd, input logic ld, input logic rfe,
                      input logic br, input logic mw);
    exp_t e;
    bit   uses_loaded, stall_now, moves;
    @(posedge clk);
    #1;
    reset = r; id_rs = rs; id_rt = rt; id_uses_rt = urt; ex_rd = rd;
    ex_load = ld; ex_rf_enable = rfe; branch_taken = br; mem_wait = mw;
    if (r) begin
      e.pc_le = 0; e.ifid_le = 0; e.idex_nop = 1; e.ifid_flush = 1; e.pipe_freeze = 0;
      e.st = 2'd0; e.cnt = 16'd0;
      m_bubbled = 0; m_flush_due = 0; m_frozen = 0; m_stalls = 0;
    end else begin
      uses_loaded = ld && rfe && (rd != 0) && ((rd == rs) || (urt && rd == rt));
      stall_now   = uses_loaded && !m_bubbled;
      moves       = !mw && !stall_now;
      e.pc_le = moves; e.ifid_le = moves;
      e.idex_nop = !mw && stall_now;
      e.ifid_flush = m_flush_due && !mw;
      e.pipe_freeze = mw;
      e.st = m_frozen ? 2'd3 : m_bubbled ? 2'd1 : m_flush_due ? 2'd2 : 2'd0;
      e.cnt = CNT_EN ? 16'(m_stalls) : 16'd0;
      m_frozen    = mw;
      m_bubbled   = !mw && stall_now;
      m_flush_due = !mw && !stall_now && br;
      if (!moves && m_stalls < 65535) m_stalls++;
    end
    q.push_back(e);
  endtask

  task automatic idle();
    step(0, 5'd1, 5'd2, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin : monitor
    exp_t e, a;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        a.pc_le = pc_le; a.ifid_le = ifid_le; a.idex_nop = idex_nop; a.ifid_flush = ifid_flush;
        a.pipe_freeze = pipe_freeze; a.st = ctrl_state; a.cnt = stall_cnt;
        checks++;
        if (a !== e) begin
          failures++;
          $display("FAIL scoreboard t=%0t actual{pc,ifid,nop,flush,frz,st,cnt}=%b,%b,%b,%b,%b,%0d,%0h expected=%b,%b,%b,%b,%b,%0d,%0h",
                   $time, a.pc_le, a.ifid_le, a.idex_nop, a.ifid_flush, a.pipe_freeze, a.st, a.cnt,
                   e.pc_le, e.ifid_le, e.idex_nop, e.ifid_flush, e.pipe_freeze, e.st, e.cnt);
        end
      end
    end
  end

  initial begin : stimulus
    #2;
    chk("reset_pc_le", 32'(pc_le), 0);
    chk("reset_idex_nop", 32'(idex_nop), 1);
    chk("reset_ifid_flush", 32'(ifid_flush), 1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle();
    chk("reset_state", 32'(ctrl_state), 0);

    // load-use on rs
    step(0, 5'd8, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0);
    #1;
    chk("lu_pc_le", 32'(pc_le), 0);
    chk("lu_ifid_le", 32'(ifid_le), 0);
    chk("lu_idex_nop", 32'(idex_nop), 1);
    step(0, 5'd8, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0);
    #1;
    chk("lu_next_state", 32'(ctrl_state), 1);
    chk("lu_next_pc_le", 32'(pc_le), 1);
    chk("lu_next_idex_nop", 32'(idex_nop), 0);
    idle();

    // r0 and unused-rt filters
    step(0, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    #1;
    chk("r0_no_stall", 32'(pc_le), 1);
    step(0, 5'd1, 5'd9, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0);
    #1;
    chk("rt_unused_no_stall", 32'(pc_le), 1);

    // branch flush
    step(0, 5'd1, 5'd2, 1'b1, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0);
    idle();
    #1;
    chk("br_state", 32'(ctrl_state), 2);
    chk("br_flush", 32'(ifid_flush), 1);
    idle();
    #1;
    chk("br_after_state", 32'(ctrl_state), 0);
    chk("br_after_flush", 32'(ifid_flush), 0);

    // freeze during a hazard
    for (int i = 0; i < 3; i++) begin
      step(0, 5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1);
      #1;
      chk("frz_pipe_freeze", 32'(pipe_freeze), 1);
      chk("frz_pc_le", 32'(pc_le), 0);
      chk("frz_idex_nop", 32'(idex_nop), 0);
    end
    idle();
    #1;
    chk("frz_state", 32'(ctrl_state), 3);
    idle();
    #1;
    chk("frz_release_state", 32'(ctrl_state), 0);

    // asynchronous reset in BUBBLE
    step(0, 5'd4, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0);
    idle();
    #1;
    chk("mid_bubble_state", 32'(ctrl_state), 1);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_state", 32'(ctrl_state), 0);
    chk("async_rst_pc_le", 32'(pc_le), 0);
    chk("async_rst_ifid_le", 32'(ifid_le), 0);
    chk("async_rst_idex_nop", 32'(idex_nop), 1);
    chk("async_rst_flush", 32'(ifid_flush), 1);
    chk("async_rst_freeze", 32'(pipe_freeze), 0);
    chk("async_rst_cnt", 32'(stall_cnt), 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle();
    #1;
    chk("post_rst_state", 32'(ctrl_state), 0);

    // randomized traffic with small register numbers to make hazards frequent
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 49) == 0),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
           5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom_range(0, 3) != 0),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0));
    end

`ifdef HAZARD_STALL_CNT_EN
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 65534; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle();
    #1;
    chk("cnt_preload", 32'(stall_cnt), 32'hFFFE);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle();
    #1;
    chk("cnt_saturate", 32'(stall_cnt), 32'hFFFF);
    idle();
    #1;
    chk("cnt_hold", 32'(stall_cnt), 32'hFFFF);
`else
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle();
    #1;
    chk("cnt_tied_zero", 32'(stall_cnt), 0);
`endif

    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", 32'(q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
